// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath widths, NOP encoding, reset vector and
// the fetch slot record carried between fetch and the IF/ID register.
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc4;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } slot_t;
endpackage

// File: rtl/if_slot_queue.sv
// In-order fetch slot queue: slots are allocated on grant, filled on
// response and retired at the head; a flush empties everything.
module if_slot_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [ADDR_W-1:0]        alloc_pc4_i,
  input  logic                     fill_i,
  input  logic [INSTR_W-1:0]       fill_data_i,
  input  logic                     pop_i,
  output logic                     head_vld_o,
  output logic [INSTR_W-1:0]       head_instr_o,
  output logic [ADDR_W-1:0]        head_pc4_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   unfilled_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  slot_t [DEPTH-1:0] slot_q, slot_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;

  logic [IW-1:0] aidx, fidx, hidx;
  assign aidx = alloc_q[IW-1:0];
  assign fidx = fill_q[IW-1:0];
  assign hidx = head_q[IW-1:0];

  // Pointers carry a wrap bit so differences give occupancy directly.
  assign count_o      = alloc_q - head_q;
  assign unfilled_o   = alloc_q - fill_q;
  assign head_vld_o   = slot_q[hidx].filled;
  assign head_instr_o = slot_q[hidx].instr;
  assign head_pc4_o   = slot_q[hidx].pc4;

  always_comb begin
    slot_d  = slot_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i].filled = 1'b0;
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
    end else begin
      if (pop_i) begin
        slot_d[hidx].filled = 1'b0;
        head_d = head_q + PW'(1);
      end
      if (alloc_i) begin
        slot_d[aidx].pc4    = alloc_pc4_i;
        slot_d[aidx].filled = 1'b0;
        alloc_d = alloc_q + PW'(1);
      end
      if (fill_i) begin
        slot_d[fidx].instr  = fill_data_i;
        slot_d[fidx].filled = 1'b1;
        fill_d = fill_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
    end else begin
      slot_q  <= slot_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, request issue to variable-latency imem,
// wrong-path response dropping and presentation of the head slot to IF/ID.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                DEPTH    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               StallF,
  input  logic               PCSrcD,
  input  logic [ADDR_W-1:0]  PCBranchD,
  output logic               IM_REQ,
  output logic [ADDR_W-1:0]  IM_ADDR,
  input  logic               IM_GNT,
  input  logic               IM_RVALID,
  input  logic [INSTR_W-1:0] IM_RDATA,
  output logic [INSTR_W-1:0] InstrF,
  output logic [ADDR_W-1:0]  PCPlus4F,
  output logic               ValidF
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(2 * DEPTH + 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DW-1:0]      drop_q, drop_d;
  logic [PW-1:0]      count, unfilled;
  logic               head_vld, pop, grant;
  logic               drop_rsp, fill_ok, fill;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc4;

  assign pop      = head_vld && !StallF && !PCSrcD;
  assign IM_REQ   = !PCSrcD && (count < PW'(DEPTH) || pop);
  assign IM_ADDR  = pc_q;
  assign grant    = IM_REQ && IM_GNT;
  assign drop_rsp = IM_RVALID && (drop_q != '0);
  assign fill_ok  = IM_RVALID && (drop_q == '0) && (unfilled != '0);
  assign fill     = fill_ok && !PCSrcD;

  assign ValidF   = head_vld;
  assign InstrF   = head_vld ? head_instr : NOP;
  assign PCPlus4F = head_vld ? head_pc4 : '0;

  // Everything still owed by memory becomes wrong-path once redirected.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (PCSrcD) begin
      pc_d   = PCBranchD;
      drop_d = drop_q + DW'(unfilled) - DW'(drop_rsp || fill_ok);
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      if (drop_rsp) drop_d = drop_q - DW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  if_slot_queue #(.DEPTH(DEPTH)) u_slots (
    .clk_i        (CLK),
    .rst_i        (RST),
    .flush_i      (PCSrcD),
    .alloc_i      (grant),
    .alloc_pc4_i  (pc_q + 32'd4),
    .fill_i       (fill),
    .fill_data_i  (IM_RDATA),
    .pop_i        (pop),
    .head_vld_o   (head_vld),
    .head_instr_o (head_instr),
    .head_pc4_o   (head_pc4),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

  a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (RST)
    IM_RVALID |-> (drop_q != '0 || unfilled != '0));
endmodule
